// File: rtl/fc_weight_mem_server.sv
// -----------------------------------------------------------------------------
// fc_weight_mem_server
//
// Weight/bias memory sitting at the far end of the FC engine's weight-fetch
// interface. The FC DMA presents mem_addr and receives mem_data one clock
// later; this read path runs every cycle regardless of load activity. A
// streamed load port (valid/ready) lets a host or boot loader fill the array
// before inference; a burst is refused while the FC engine is busy.
//
// Optional feature (macro WMEM_CHECKSUM_EN):
//   Adds load_checksum, the modulo-2**WORD_SIZE sum of the words accepted in
//   the current burst. Cleared on an accepted load_start and on reset. When
//   the macro is undefined the port and its adder are absent.
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous, active-low reset
//   mem_addr      read address from the FC DMA
//   mem_data      registered read data, valid one cycle after mem_addr
//                 (0 for addresses >= MEM_DEPTH)
//   fc_busy       FC inference in progress; load_start is rejected
//   load_start    one-cycle pulse starting a burst
//   load_base     first write address, sampled on load_start
//   load_count    burst length in words, sampled on load_start
//   load_valid    host presents load_data
//   load_data     word to write
//   load_ready    block accepts a word this cycle (high throughout LOAD)
//   load_done     one-cycle pulse when a burst completes
//   load_err      one-cycle pulse after a rejected load_start
//   load_checksum (WMEM_CHECKSUM_EN only) running sum of the burst
// -----------------------------------------------------------------------------
module fc_weight_mem_server #(
  parameter int unsigned WORD_SIZE         = 16,
  parameter int unsigned MEM_ADDRESS_WIDTH = 10,
  parameter int unsigned MEM_DEPTH         = 1024,
  parameter int unsigned LOAD_COUNT_WIDTH  = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MEM_ADDRESS_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]         mem_data,
  input  logic                         fc_busy,
  input  logic                         load_start,
  input  logic [MEM_ADDRESS_WIDTH-1:0] load_base,
  input  logic [LOAD_COUNT_WIDTH-1:0]  load_count,
  input  logic                         load_valid,
  input  logic [WORD_SIZE-1:0]         load_data,
  output logic                         load_ready,
  output logic                         load_done,
  output logic                         load_err
`ifdef WMEM_CHECKSUM_EN
  ,
  output logic [WORD_SIZE-1:0]         load_checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  localparam logic [MEM_ADDRESS_WIDTH-1:0] LAST_ADDR = MEM_ADDRESS_WIDTH'(MEM_DEPTH - 1);

  logic [WORD_SIZE-1:0] mem_array [MEM_DEPTH];

  state_e                         state_q,     state_d;
  logic [MEM_ADDRESS_WIDTH-1:0]   waddr_q,     waddr_d;
  logic [LOAD_COUNT_WIDTH-1:0]    remaining_q, remaining_d;
  logic [WORD_SIZE-1:0]           mem_data_q,  mem_data_d;
  logic                           load_err_q,  load_err_d;

  logic                           accept;
  logic                           start_ok;
  logic                           mem_we;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    remaining_d = remaining_q;
    load_err_d  = 1'b0;
    start_ok    = 1'b0;
    accept      = (state_q == S_LOAD) && load_valid;

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          if (fc_busy) begin
            load_err_d = 1'b1;
          end else begin
            start_ok = 1'b1;
            if (load_count == '0) begin
              state_d = S_DONE;
            end else begin
              waddr_d     = load_base;
              remaining_d = load_count;
              state_d     = S_LOAD;
            end
          end
        end
      end

      S_LOAD: begin
        // load_start is ignored here and fc_busy does not abort the burst.
        if (accept) begin
          waddr_d     = (waddr_q == LAST_ADDR) ? '0 : waddr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LOAD_COUNT_WIDTH'(1)) state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Out-of-range writes (base beyond MEM_DEPTH) are dropped; the write is
    // also suppressed on a reset edge so a burst cut by reset stops cleanly.
    mem_we = accept && rst && (32'(waddr_q) < MEM_DEPTH);

    // Reads see the array before this edge's write lands: read-before-write.
    mem_data_d = '0;
    if (32'(mem_addr) < MEM_DEPTH) mem_data_d = mem_array[mem_addr];
  end

  // ---------------------------------------------------------------------------
  // Control and read-data registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      remaining_q <= '0;
      mem_data_q  <= '0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      remaining_q <= remaining_d;
      mem_data_q  <= mem_data_d;
      load_err_q  <= load_err_d;
    end
  end

  // NOTE: the array has no reset; contents survive rst so weights loaded
  // once remain valid, and a resettable array would not map to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_array[waddr_q] <= load_data;
  end

  assign mem_data   = mem_data_q;
  assign load_ready = (state_q == S_LOAD);
  assign load_done  = (state_q == S_DONE);
  assign load_err   = load_err_q;

`ifdef WMEM_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Burst checksum: wraps naturally at WORD_SIZE bits.
  // ---------------------------------------------------------------------------
  logic [WORD_SIZE-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_ok)    checksum_d = '0;
    else if (accept) checksum_d = checksum_q + load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) checksum_q <= '0;
    else      checksum_q <= checksum_d;
  end

  assign load_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_fc_weight_mem_server.sv
// -----------------------------------------------------------------------------
// tb_fc_weight_mem_server
//
// Directed bench for fc_weight_mem_server. A second instance with
// MEM_DEPTH=1000 shares the load port and is used for out-of-range reads.
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point.
// -----------------------------------------------------------------------------
module tb_fc_weight_mem_server;

  localparam int AW = 10;
  localparam int WS = 16;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [AW-1:0] mem_addr_s = '0;
  logic [WS-1:0] mem_data;
  logic [WS-1:0] mem_data_s;
  logic          fc_busy = 1'b0;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [CW-1:0] load_count = '0;
  logic          load_valid = 1'b0;
  logic [WS-1:0] load_data = '0;
  logic          load_ready, load_done, load_err;
  logic          load_ready_s, load_done_s, load_err_s;
`ifdef WMEM_CHECKSUM_EN
  logic [WS-1:0] load_checksum;
  logic [WS-1:0] load_checksum_s;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fc_weight_mem_server #(
    .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW), .MEM_DEPTH(1024), .LOAD_COUNT_WIDTH(CW)
  ) u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
    .fc_busy(fc_busy), .load_start(load_start), .load_base(load_base),
    .load_count(load_count), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .load_err(load_err)
`ifdef WMEM_CHECKSUM_EN
    , .load_checksum(load_checksum)
`endif
  );

  fc_weight_mem_server #(
    .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW), .MEM_DEPTH(1000), .LOAD_COUNT_WIDTH(CW)
  ) u_small (
    .clk(clk), .rst(rst), .mem_addr(mem_addr_s), .mem_data(mem_data_s),
    .fc_busy(fc_busy), .load_start(load_start), .load_base(load_base),
    .load_count(load_count), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready_s), .load_done(load_done_s), .load_err(load_err_s)
`ifdef WMEM_CHECKSUM_EN
    , .load_checksum(load_checksum_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle load_start pulse; returns after the sampling edge.
  task automatic start_load(input logic [AW-1:0] base, input logic [CW-1:0] count);
    load_start = 1'b1;
    load_base  = base;
    load_count = count;
    tick();
    load_start = 1'b0;
  endtask

  // Optional stall cycles with load_valid low, then one accepted word.
  task automatic send_word(input logic [WS-1:0] data, input int stall, input string tag);
    int budget;
    load_valid = 1'b0;
    for (int i = 0; i < stall; i++) tick();
    load_valid = 1'b1;
    load_data  = data;
    budget = 0;
    while (!load_ready && budget < 20) begin
      tick();
      budget++;
    end
    check(tag, 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
  endtask

  // Present an address; data is checked one cycle later.
  task automatic read_check(input logic [AW-1:0] addr, input logic [WS-1:0] exp, input string tag);
    mem_addr = addr;
    tick();
    check(tag, 32'(mem_data), 32'(exp));
  endtask

  initial begin
    bit seen_done;

    // ---- Reset ----
    tick();
    tick();
    check("rst_mem_data",   32'(mem_data),   32'h0);
    check("rst_load_ready", 32'(load_ready), 32'h0);
    check("rst_load_done",  32'(load_done),  32'h0);
    check("rst_load_err",   32'(load_err),   32'h0);
    rst = 1'b1;
    tick();

    // ---- Basic load base=0 count=4, continuous ----
    start_load(10'd0, 11'd4);                                  // cycle 1
    check("basic_ready", 32'(load_ready), 32'd1);
    send_word(16'h0001, 0, "basic_w0");                        // cycle 2
    send_word(16'h0002, 0, "basic_w1");                        // cycle 3
    send_word(16'h0003, 0, "basic_w2");                        // cycle 4
    check("basic_no_done_early", 32'(load_done), 32'd0);
    send_word(16'h0004, 0, "basic_w3");                        // cycle 5
    check("basic_done_at_5", 32'(load_done), 32'd1);
    check("basic_ready_off", 32'(load_ready), 32'd0);
    tick();
    check("basic_done_one_cycle", 32'(load_done), 32'd0);
    read_check(10'd0, 16'h0001, "basic_rd0");
    read_check(10'd1, 16'h0002, "basic_rd1");
    read_check(10'd2, 16'h0003, "basic_rd2");
    read_check(10'd3, 16'h0004, "basic_rd3");

    // ---- Busy rejection at base=10 ----
    start_load(10'd10, 11'd1);
    send_word(16'h5A5A, 0, "busy_pre_w");
    tick();
    fc_busy = 1'b1;
    start_load(10'd10, 11'd2);
    check("busy_err_pulse", 32'(load_err),   32'd1);
    check("busy_ready_0",   32'(load_ready), 32'd0);
    load_valid = 1'b1;
    load_data  = 16'hDEAD;
    tick();
    check("busy_err_once",  32'(load_err),   32'd0);
    check("busy_ready_0b",  32'(load_ready), 32'd0);
    tick();
    load_valid = 1'b0;
    fc_busy    = 1'b0;
    read_check(10'd10, 16'h5A5A, "busy_arr10");

    // ---- Stall and wrap-around ----
    start_load(10'd1022, 11'd3);
    send_word(16'hAAAA, 0, "wrap_w0");
    send_word(16'hBBBB, 2, "wrap_w1");
    check("wrap_no_done_early", 32'(load_done), 32'd0);
    send_word(16'hCCCC, 2, "wrap_w2");
    check("wrap_done", 32'(load_done), 32'd1);
    tick();
    read_check(10'd1022, 16'hAAAA, "wrap_rd1022");
    read_check(10'd1023, 16'hBBBB, "wrap_rd1023");
    read_check(10'd0,    16'hCCCC, "wrap_rd0");

    // ---- Read/write collision on address 5 ----
    start_load(10'd5, 11'd1);
    send_word(16'h1111, 0, "coll_pre_w");
    tick();
    start_load(10'd5, 11'd1);
    mem_addr = 10'd5;
    send_word(16'h2222, 0, "coll_w");
    check("coll_old_data", 32'(mem_data), 32'h1111);
    check("coll_done",     32'(load_done), 32'd1);
    tick();
    check("coll_new_data", 32'(mem_data), 32'h2222);

    // ---- Out-of-range read on the 1000-deep instance ----
    mem_addr_s = 10'd3;
    tick();
    check("oor_in_range", 32'(mem_data_s), 32'h0004);
    mem_addr_s = 10'd1000;
    tick();
    check("oor_1000", 32'(mem_data_s), 32'h0);
    mem_addr_s = 10'd1023;
    tick();
    check("oor_1023", 32'(mem_data_s), 32'h0);

    // ---- count=0: straight to DONE, no writes ----
    load_valid = 1'b1;
    load_data  = 16'hBAD0;
    start_load(10'd0, 11'd0);
    check("cnt0_done",  32'(load_done),  32'd1);
    check("cnt0_ready", 32'(load_ready), 32'd0);
    tick();
    load_valid = 1'b0;
    check("cnt0_done_once", 32'(load_done), 32'd0);
    read_check(10'd0, 16'hCCCC, "cnt0_arr0");

    // ---- Reset after 2 of 5 words ----
    start_load(10'd100, 11'd5);
    send_word(16'h0100, 0, "mrst_w0");
    send_word(16'h0101, 0, "mrst_w1");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mrst_ready_0", 32'(load_ready), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (load_done) seen_done = 1'b1;
      tick();
    end
    check("mrst_no_done", 32'(seen_done), 32'd0);
    read_check(10'd100, 16'h0100, "mrst_rd100");
    read_check(10'd101, 16'h0101, "mrst_rd101");

`ifdef WMEM_CHECKSUM_EN
    // ---- Checksum: 0xFFFF + 0x0003 = 0x0002 (mod 2**16) ----
    start_load(10'd200, 11'd2);
    check("cks_cleared", 32'(load_checksum), 32'h0);
    send_word(16'hFFFF, 0, "cks_w0");
    send_word(16'h0003, 0, "cks_w1");
    check("cks_done", 32'(load_done), 32'd1);
    check("cks_value", 32'(load_checksum), 32'h0002);
    tick();
    check("cks_stable", 32'(load_checksum), 32'h0002);
    start_load(10'd300, 11'd1);
    check("cks_clear_on_start", 32'(load_checksum), 32'h0);
    send_word(16'h0007, 0, "cks_w2");
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
